// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-request lookahead.
// Optional colour-bar test pattern is enabled by defining VGA_TESTPATTERN_EN.
module vga_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   LOOKAHEAD = 1,
  parameter int   CW        = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [7:0]    R,
  input  logic [7:0]    G,
  input  logic [7:0]    B,
`ifdef VGA_TESTPATTERN_EN
  input  logic          pattern_sel,
`endif
  output logic [CW-1:0] req_x,
  output logic [CW-1:0] req_y,
  output logic          req_valid,
  output logic          frame_start,
  output logic          line_start,
  output logic [7:0]    VGA_R,
  output logic [7:0]    VGA_G,
  output logic [7:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_N,
  output logic          VGA_SYNC_N
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_END_A = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_END_F = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] H_END_S = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_END_A = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_END_F = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] V_END_S = CW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);

  if (LOOKAHEAD < 0 || LOOKAHEAD > 4) begin : g_bad_lookahead
    $error("vga_timing_gen: LOOKAHEAD must be in 0..4");
  end
  if (H_TOTAL > (2 ** CW) || V_TOTAL > (2 ** CW)) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for raster totals");
  end

  logic [CW-1:0] r_hc;
  logic [CW-1:0] r_vc;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_h_acti;
  logic          w_v_acti;
  logic          w_h_sync;
  logic          w_v_sync;

  assign w_h_wrap = (r_hc == H_LAST);
  assign w_v_wrap = (r_vc == V_LAST);

  // Raster counters: vc steps only on the hc wrap, so both wrap together at frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (en) begin
      r_hc <= w_h_wrap ? '0 : r_hc + CW'(1);
      if (w_h_wrap) begin
        r_vc <= w_v_wrap ? '0 : r_vc + CW'(1);
      end
    end
  end

  assign w_h_acti = (r_hc < H_END_A);
  assign w_v_acti = (r_vc < V_END_A);
  assign w_h_sync = (r_hc >= H_END_F) && (r_hc < H_END_S);
  assign w_v_sync = (r_vc >= V_END_F) && (r_vc < V_END_S);

  assign req_valid   = w_h_acti & w_v_acti;
  assign req_x       = req_valid ? r_hc : '0;
  assign req_y       = req_valid ? r_vc : '0;
  assign frame_start = en & (r_hc == '0) & (r_vc == '0);
  assign line_start  = en & (r_hc == '0) & w_v_acti;

`ifdef VGA_TESTPATTERN_EN
  localparam int PW = 3 + CW;
  if (H_ACTIVE < 8) begin : g_bad_bars
    $error("vga_timing_gen: H_ACTIVE too small for 8 colour bars");
  end
`else
  localparam int PW = 3;
`endif

  logic [PW-1:0] w_tap;
  logic [PW-1:0] w_tap_d;

`ifdef VGA_TESTPATTERN_EN
  assign w_tap = {req_x, req_valid, w_v_sync, w_h_sync};
`else
  assign w_tap = {req_valid, w_v_sync, w_h_sync};
`endif

  // Lookahead delay line: realigns sync/blank with the pixel source latency
  if (LOOKAHEAD == 0) begin : g_nodly
    assign w_tap_d = w_tap;
  end else begin : g_dly
    logic [PW-1:0] r_tap_p [LOOKAHEAD];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < LOOKAHEAD; i++) r_tap_p[i] <= '0;
      end else if (en) begin
        r_tap_p[0] <= w_tap;
        for (int i = 1; i < LOOKAHEAD; i++) r_tap_p[i] <= r_tap_p[i-1];
      end
    end
    assign w_tap_d = r_tap_p[LOOKAHEAD-1];
  end

  logic        w_hs_d;
  logic        w_vs_d;
  logic        w_de_d;
  logic [23:0] w_pix;

  assign w_hs_d = w_tap_d[0];
  assign w_vs_d = w_tap_d[1];
  assign w_de_d = w_tap_d[2];

`ifdef VGA_TESTPATTERN_EN
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction

  localparam logic [CW-1:0] BAR_W = CW'(H_ACTIVE / 8);
  logic [CW-1:0] w_x_d;
  logic [CW-1:0] w_bar_q;
  logic [2:0]    w_bar;

  assign w_x_d   = w_tap_d[PW-1:3];
  assign w_bar_q = w_x_d / BAR_W;
  assign w_bar   = (w_bar_q > CW'(7)) ? 3'd7 : w_bar_q[2:0];
  assign w_pix   = pattern_sel ? bar_rgb(w_bar) : {R, G, B};
`else
  assign w_pix   = {R, G, B};
`endif

  // Output register stage driving the DAC pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_BLANK_N <= 1'b0;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
    end else if (en) begin
      {VGA_R, VGA_G, VGA_B} <= w_de_d ? w_pix : 24'h000000;
      VGA_BLANK_N <= w_de_d;
      VGA_HS      <= w_hs_d ? HS_POL : ~HS_POL;
      VGA_VS      <= w_vs_d ? VS_POL : ~VS_POL;
    end
  end

  assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a small-raster
// instance with LOOKAHEAD=2 and active-high syncs fed by a latency-matched source.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic en_a, en_b;
  always #5 clk = ~clk;

  // Instance A: default 640x480 timing
  logic [7:0]  R_a, G_a, B_a;
  logic [10:0] req_x_a, req_y_a;
  logic        rv_a, fs_a, ls_a;
  logic [7:0]  vr_a, vg_a, vb_a;
  logic        hs_a, vs_a, bl_a, sn_a;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .R(R_a), .G(G_a), .B(B_a),
`ifdef VGA_TESTPATTERN_EN
    .pattern_sel(1'b0),
`endif
    .req_x(req_x_a), .req_y(req_y_a), .req_valid(rv_a),
    .frame_start(fs_a), .line_start(ls_a),
    .VGA_R(vr_a), .VGA_G(vg_a), .VGA_B(vb_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(bl_a), .VGA_SYNC_N(sn_a)
  );

  // Instance B: 24x8 raster, LOOKAHEAD=2, active-high syncs
  logic [7:0] R_b, G_b, B_b;
  logic [5:0] req_x_b, req_y_b;
  logic       rv_b, fs_b, ls_b;
  logic [7:0] vr_b, vg_b, vb_b;
  logic       hs_b, vs_b, bl_b, sn_b;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .LOOKAHEAD(2), .CW(6)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .R(R_b), .G(G_b), .B(B_b),
`ifdef VGA_TESTPATTERN_EN
    .pattern_sel(1'b0),
`endif
    .req_x(req_x_b), .req_y(req_y_b), .req_valid(rv_b),
    .frame_start(fs_b), .line_start(ls_b),
    .VGA_R(vr_b), .VGA_G(vg_b), .VGA_B(vb_b),
    .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(bl_b), .VGA_SYNC_N(sn_b)
  );

  // Pixel source model for B: returns req_x with two enabled cycles of latency
  logic [7:0] src1, src2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src1 <= 8'h00;
      src2 <= 8'h00;
    end else if (en_b) begin
      src1 <= {2'b00, req_x_b};
      src2 <= src1;
    end
  end
  assign R_b = src2;
  assign G_b = 8'h11;
  assign B_b = 8'h22;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    int   t;
    logic fs, ls, rv;
    int   rx, ry;
    logic hs, bl;
    int   vr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int t_a;
    int hs_lo, bl_hi, vs_hi;
    int ls_t[$];
    logic [7:0]  p_vr, c_vr;
    logic [10:0] p_rx, c_rx;
    logic        p_hs, c_hs, p_bl, c_bl, last_en;
    int run, last_r, hs_hi_b, vs_hi_b, fs_last, nfs, guard;
    logic pbl;

    // t, fs, ls, rv, rx, ry, hs, bl, vr  (A: LOOKAHEAD=1, pins lag counters by 2)
    vecs[0]  = '{0,   1, 1, 1, 0, 0, 1, 0, 0};
    vecs[1]  = '{1,   0, 0, 1, 1, 0, 1, 0, 0};
    vecs[2]  = '{2,   0, 0, 1, 2, 0, 1, 1, 'hA5};
    vecs[3]  = '{641, 0, 0, 0, 0, 0, 1, 1, 'hA5};
    vecs[4]  = '{642, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[5]  = '{657, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[6]  = '{658, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{753, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{754, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[9]  = '{799, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[10] = '{800, 0, 1, 1, 0, 1, 1, 0, 0};
    vecs[11] = '{802, 0, 0, 1, 2, 1, 1, 1, 'hA5};

    R_a = 8'hA5; G_a = 8'h5A; B_a = 8'h3C;
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
    repeat (3) tick();

    chk("rst_a_hs", hs_a, 1);
    chk("rst_a_vs", vs_a, 1);
    chk("rst_a_blank", bl_a, 0);
    chk("rst_a_r", vr_a, 0);
    chk("rst_a_sync_n", sn_a, 0);
    chk("rst_a_req_valid", rv_a, 1);
    chk("rst_b_hs", hs_b, 0);
    chk("rst_b_vs", vs_b, 0);

    rst_n = 1'b1;
    en_a  = 1'b1;
    #1;
    t_a = 0;
    foreach (vecs[i]) begin
      while (t_a < vecs[i].t) begin
        tick();
        t_a++;
      end
      chk($sformatf("a_fs_t%0d", vecs[i].t), fs_a, vecs[i].fs);
      chk($sformatf("a_ls_t%0d", vecs[i].t), ls_a, vecs[i].ls);
      chk($sformatf("a_rv_t%0d", vecs[i].t), rv_a, vecs[i].rv);
      chk($sformatf("a_rx_t%0d", vecs[i].t), req_x_a, vecs[i].rx);
      chk($sformatf("a_ry_t%0d", vecs[i].t), req_y_a, vecs[i].ry);
      chk($sformatf("a_hs_t%0d", vecs[i].t), hs_a, vecs[i].hs);
      chk($sformatf("a_bl_t%0d", vecs[i].t), bl_a, vecs[i].bl);
      chk($sformatf("a_vr_t%0d", vecs[i].t), vr_a, vecs[i].vr);
    end

    // One full line window on A
    hs_lo = 0; bl_hi = 0; vs_hi = 0;
    for (int c = 0; c < 800; c++) begin
      tick();
      if (!hs_a) hs_lo++;
      if (bl_a)  bl_hi++;
      if (vs_a)  vs_hi++;
    end
    chk("a_hs_low_per_line", hs_lo, 96);
    chk("a_blank_hi_per_line", bl_hi, 640);
    chk("a_vs_idle_high", vs_hi, 800);

    // en toggling on A: line period doubles and pins freeze on disabled cycles
    last_en = 1'b1;
    p_vr = vr_a; p_rx = req_x_a; p_hs = hs_a; p_bl = bl_a;
    for (int c = 0; c < 3400; c++) begin
      en_a = (c % 2 == 0);
      #1;
      c_vr = vr_a; c_rx = req_x_a; c_hs = hs_a; c_bl = bl_a;
      if (!last_en) begin
        chk("a_hold_r", c_vr, p_vr);
        chk("a_hold_rx", c_rx, p_rx);
        chk("a_hold_hs", c_hs, p_hs);
        chk("a_hold_bl", c_bl, p_bl);
      end
      if (ls_a) ls_t.push_back(c);
      p_vr = c_vr; p_rx = c_rx; p_hs = c_hs; p_bl = c_bl;
      last_en = en_a;
      tick();
    end
    chk("a_ls_pulses_seen", ls_t.size() >= 2, 1);
    if (ls_t.size() >= 2) chk("a_line_period_toggled", ls_t[1] - ls_t[0], 1600);
    en_a = 1'b1;

    // Instance B from reset with its latency-matched source
    en_b = 1'b1;
    #1;
    chk("b_fs_t0", fs_b, 1);
    chk("b_rx_t0", req_x_b, 0);
    chk("b_ry_t0", req_y_b, 0);
    chk("b_rv_t0", rv_b, 1);
    run = 0; last_r = 0; hs_hi_b = 0; vs_hi_b = 0; fs_last = 0; nfs = 0; pbl = 1'b0;
    for (int t = 1; t <= 400; t++) begin
      tick();
      if (fs_b) begin
        chk("b_frame_period", t - fs_last, 192);
        fs_last = t;
        nfs++;
      end
      if (t >= 3 && t < 195) begin
        if (hs_b) hs_hi_b++;
        if (vs_b) vs_hi_b++;
      end
      if (bl_b) begin
        chk($sformatf("b_pixel_t%0d", t), vr_b, run);
        last_r = vr_b;
        run++;
      end else if (pbl) begin
        chk("b_line_len", run, 16);
        chk("b_last_px", last_r, 15);
        run = 0;
      end
      pbl = bl_b;
    end
    chk("b_hs_high_per_frame", hs_hi_b, 24);
    chk("b_vs_high_per_frame", vs_hi_b, 48);
    chk("b_frame_starts", nfs, 2);

    // Mid-line reset on B while pixels are visible
    guard = 0;
    while (!(bl_b && vr_b >= 8'd5) && guard < 100) begin
      tick();
      guard++;
    end
    chk("b_active_before_reset", guard < 100, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("b_async_blank", bl_b, 0);
    chk("b_async_r", vr_b, 0);
    chk("b_async_hs", hs_b, 0);
    chk("b_async_vs", vs_b, 0);
    chk("b_async_rx", req_x_b, 0);
    chk("b_async_ry", req_y_b, 0);
    tick();
    #1 rst_n = 1'b1;
    #1;
    chk("b_rel_fs", fs_b, 1);
    chk("b_rel_rv", rv_b, 1);
    chk("b_rel_rx", req_x_b, 0);
    chk("b_rel_ry", req_y_b, 0);
    tick();
    chk("b_rel_fs_drop", fs_b, 0);
    chk("b_rel_rx1", req_x_b, 1);
    chk("b_rel_blank_still_low", bl_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
